// File: rtl/game_control.sv
// Autonomous falling-block game engine: spawns pseudo-random tetrominoes on a 10x20 field,
// applies gravity, locks pieces, clears full rows and freezes on game over.
module game_control #(
  parameter int unsigned DROP_PERIOD = 10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [199:0] objects
);

  localparam int unsigned CntW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DROP_PERIOD - 1);

  typedef enum logic [1:0] {
    StSpawn,
    StFall,
    StClear,
    StGameOver
  } state_e;

  state_e          state_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [199:0]    board_q;
  logic            valid_q;
  logic [2:0]      type_q;
  logic [3:0]      col_q;
  logic [4:0]      row_q;
  logic [CntW-1:0] cnt_q;
  logic [4:0]      scan_q;

  // Shape as two 4-bit row masks {row1, row0}; bit k of a row mask is column offset k.
  function automatic logic [7:0] shape(input logic [2:0] t);
    logic [7:0] s;
    case (t)
      3'd1:    s = {4'b0011, 4'b0011};
      3'd2:    s = {4'b0010, 4'b0111};
      3'd3:    s = {4'b0011, 4'b0110};
      3'd4:    s = {4'b0110, 4'b0011};
      3'd5:    s = {4'b0111, 4'b0001};
      3'd6:    s = {4'b0111, 4'b0100};
      default: s = {4'b0000, 4'b1111};
    endcase
    return s;
  endfunction

  function automatic logic [199:0] place(input logic [7:0] s, input logic [3:0] col,
                                         input logic [4:0] row);
    logic [9:0]   l0, l1;
    logic [199:0] m;
    l0 = {6'd0, s[3:0]} << col;
    l1 = {6'd0, s[7:4]} << col;
    m  = {180'd0, l1, l0};
    return m << (8'(row) * 8'd10);
  endfunction

  logic [2:0]   spawn_type;
  logic [3:0]   spawn_col;
  logic [7:0]   spawn_shape, cur_shape;
  logic [199:0] spawn_mask, cur_mask, next_mask;
  logic [5:0]   next_bottom;
  logic         can_fall;
  logic         row_full;
  logic [199:0] board_clr;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    spawn_type = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    // Column range shrinks with piece width so the piece always fits horizontally.
    case (spawn_type)
      3'd0:    spawn_col = lfsr_q[7:4] % 4'd7;
      3'd1:    spawn_col = lfsr_q[7:4] % 4'd9;
      default: spawn_col = lfsr_q[7:4] % 4'd8;
    endcase
  end

  assign spawn_shape = shape(spawn_type);
  assign cur_shape   = shape(type_q);
  assign spawn_mask  = place(spawn_shape, spawn_col, 5'd0);
  assign cur_mask    = place(cur_shape, col_q, row_q);
  assign next_mask   = place(cur_shape, col_q, row_q + 5'd1);

  // Bottom row of the piece after one more step is row_q + height.
  assign next_bottom = {1'b0, row_q} + ((|cur_shape[7:4]) ? 6'd2 : 6'd1);
  assign can_fall    = (next_bottom < 6'd20) && ((next_mask & board_q) == 200'd0);

  always_comb begin
    board_clr      = board_q;
    board_clr[9:0] = 10'd0;
    row_full       = &board_q[9:0] && (scan_q == 5'd0);
    for (int i = 1; i < 20; i++) begin
      if (5'(i) == scan_q) row_full = &board_q[i*10 +: 10];
      if (5'(i) <= scan_q) board_clr[i*10 +: 10] = board_q[(i-1)*10 +: 10];
    end
  end

  assign objects = board_q | (valid_q ? cur_mask : 200'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StSpawn;
      lfsr_q  <= LFSR_SEED;
      board_q <= '0;
      valid_q <= 1'b0;
      type_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      scan_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      unique case (state_q)
        StSpawn: begin
          type_q <= spawn_type;
          col_q  <= spawn_col;
          row_q  <= 5'd0;
          cnt_q  <= '0;
          if ((spawn_mask & board_q) != 200'd0) begin
            state_q <= StGameOver;
          end else begin
            valid_q <= 1'b1;
            state_q <= StFall;
          end
        end
        StFall: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (can_fall) begin
              row_q <= row_q + 5'd1;
            end else begin
              board_q <= board_q | cur_mask;
              valid_q <= 1'b0;
              scan_q  <= 5'd19;
              state_q <= StClear;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StClear: begin
          // A cleared row pulls the rows above down, so the same index is examined again.
          if (row_full) begin
            board_q <= board_clr;
          end else if (scan_q == 5'd0) begin
            state_q <= StSpawn;
          end else begin
            scan_q <= scan_q - 5'd1;
          end
        end
        StGameOver: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: vector table for the first two pieces, reset replay,
// and a long free run checking invariants until the game freezes.
module tb_game_control;

  localparam int TraceLen = 300;

  logic         clk;
  logic         rst;
  logic [199:0] objects;

  game_control #(
    .DROP_PERIOD(10),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .objects(objects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    int row1;
    int row2;
    int pop;
  } vec_t;

  vec_t         vecs[12];
  int           total = 0;
  int           bad = 0;
  int           ecnt = 0;
  int           mode = 0;  // 0 none, 1 record trace, 2 compare against trace
  logic [199:0] trace[1:TraceLen];
  logic [199:0] mask1, mask2, hand_first;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [199:0] piece_at(input logic [15:0] s, input int row);
    int t, w, col;
    int cr[4];
    int cc[4];
    logic [199:0] m;
    t = int'(s[2:0]);
    if (t == 7) t = 0;
    case (t)
      0:       begin cr = '{0, 0, 0, 0}; cc = '{0, 1, 2, 3}; end
      1:       begin cr = '{0, 0, 1, 1}; cc = '{0, 1, 0, 1}; end
      2:       begin cr = '{0, 0, 0, 1}; cc = '{0, 1, 2, 1}; end
      3:       begin cr = '{0, 0, 1, 1}; cc = '{1, 2, 0, 1}; end
      4:       begin cr = '{0, 0, 1, 1}; cc = '{0, 1, 1, 2}; end
      5:       begin cr = '{0, 1, 1, 1}; cc = '{0, 0, 1, 2}; end
      default: begin cr = '{2, 1, 1, 1}; cc = '{2, 0, 1, 2}; cr[0] = 0; end
    endcase
    w = (t == 0) ? 4 : (t == 1) ? 2 : 3;
    col = int'(s[7:4]) % (11 - w);
    m = '0;
    for (int k = 0; k < 4; k++) m[(row + cr[k]) * 10 + col + cc[k]] = 1'b1;
    return m;
  endfunction

  task automatic check_obj(input string name, input logic [199:0] want);
    total++;
    if (objects !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, objects, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
    if (ecnt <= TraceLen) begin
      if (mode == 1) begin
        trace[ecnt] = objects;
      end else if (mode == 2) begin
        total++;
        if (objects !== trace[ecnt]) begin
          bad++;
          $display("FAIL replay edge %0d: got %h want %h", ecnt, objects, trace[ecnt]);
        end
      end
    end
  endtask

  // Called #1 after a rising edge: asserts reset, checks the async clear, releases mid-cycle.
  task automatic pulse_reset(input string name);
    rst = 1'b0;
    #1;
    check_obj({name, "_async_clear"}, 200'd0);
    repeat (2) @(posedge clk);
    #1;
    check_obj({name, "_held"}, 200'd0);
    @(negedge clk);
    rst = 1'b1;
    ecnt = 0;
  endtask

  task automatic run_table(input int m);
    logic [199:0] want;
    mode = m;
    for (int i = 0; i < 12; i++) begin
      while (ecnt < vecs[i].edge_n) step();
      want = mask1 << (10 * vecs[i].row1);
      if (vecs[i].row2 >= 0) want = want | (mask2 << (10 * vecs[i].row2));
      check_obj($sformatf("vec%0d_objects", i), want);
      check_int($sformatf("vec%0d_popcount", i), $countones(objects), vecs[i].pop);
      if (vecs[i].edge_n == 1) begin
        check_obj("first_piece_hand", hand_first);
        check_int("first_piece_top_rows", int'(objects[199:20] != 180'd0), 0);
      end
    end
    while (ecnt < TraceLen) step();
    mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0]  s;
    logic [199:0] prev;
    int           same, full_run, max_full;
    bit           frozen, par_bad, any_full;
    int           par_val;

    vecs[0]  = '{1, 0, -1, 4};
    vecs[1]  = '{10, 0, -1, 4};
    vecs[2]  = '{11, 1, -1, 4};
    vecs[3]  = '{21, 2, -1, 4};
    vecs[4]  = '{101, 10, -1, 4};
    vecs[5]  = '{181, 18, -1, 4};
    vecs[6]  = '{190, 18, -1, 4};
    vecs[7]  = '{191, 18, -1, 4};
    vecs[8]  = '{211, 18, -1, 4};
    vecs[9]  = '{212, 18, 0, 8};
    vecs[10] = '{221, 18, 0, 8};
    vecs[11] = '{222, 18, 1, 8};

    // Seed ACE1: type 1 (O), column 14 mod 9 = 5.
    hand_first = '0;
    hand_first[5] = 1'b1;
    hand_first[6] = 1'b1;
    hand_first[15] = 1'b1;
    hand_first[16] = 1'b1;

    mask1 = piece_at(16'hACE1, 0);
    s = 16'hACE1;
    repeat (211) s = lfsr_next(s);
    mask2 = piece_at(s, 0);

    rst = 1'b0;
    #1;
    check_obj("reset_objects", 200'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ecnt = 0;

    run_table(1);

    pulse_reset("midfall_reset");
    run_table(2);

    // Free run until the field stops changing.
    prev = objects;
    same = 0;
    full_run = 0;
    max_full = 0;
    frozen = 1'b0;
    par_bad = 1'b0;
    par_val = 0;
    for (int c = 0; c < 40000 && !frozen; c++) begin
      step();
      if (($countones(objects) % 2) != 0 && !par_bad) begin
        par_bad = 1'b1;
        par_val = $countones(objects);
      end
      any_full = 1'b0;
      for (int r = 0; r < 20; r++) if (&objects[r*10 +: 10]) any_full = 1'b1;
      full_run = any_full ? full_run + 1 : 0;
      if (full_run > max_full) max_full = full_run;
      if (objects === prev) same++;
      else same = 0;
      prev = objects;
      if (same >= 150) frozen = 1'b1;
    end
    check_int("popcount_even", par_bad ? par_val % 2 : 0, 0);
    check_int("full_row_persist_le_24", (max_full > 24) ? max_full : 0, 0);
    check_int("game_over_reached", int'(frozen), 1);
    check_int("game_over_top_rows_occupied", int'(objects[19:0] != 20'd0), 1);
    repeat (50) step();
    check_obj("game_over_frozen", prev);

    pulse_reset("gameover_reset");
    run_table(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
